// File: rtl/fft_stage_sequencer_if.sv
// Control and address bundle between the FFT stage sequencer and the
// data RAM / twiddle ROM / butterfly datapath it drives.
interface fft_stage_sequencer_if #(
   parameter int N = 1024
);
   localparam int LOGN  = $clog2(N);
   localparam int TW_W  = LOGN - 1;
   localparam int STG_W = $clog2(LOGN);

   logic             start_i;
   logic             busy_o;
   logic             done_o;
   logic [LOGN-1:0]  rd_addr_x0_o;
   logic [LOGN-1:0]  rd_addr_x1_o;
   logic             rd_en_o;
   logic [TW_W-1:0]  twiddle_addr_o;
   logic             bf_ce_o;
   logic [LOGN-1:0]  wr_addr_x0_o;
   logic [LOGN-1:0]  wr_addr_x1_o;
   logic             wr_en_o;
   logic [STG_W-1:0] stage_o;
   logic [1:0]       state_o;

   modport master (
      input  start_i,
      output busy_o, done_o, rd_addr_x0_o, rd_addr_x1_o, rd_en_o,
             twiddle_addr_o, bf_ce_o, wr_addr_x0_o, wr_addr_x1_o,
             wr_en_o, stage_o, state_o
   );

   modport slave (
      output start_i,
      input  busy_o, done_o, rd_addr_x0_o, rd_addr_x1_o, rd_en_o,
             twiddle_addr_o, bf_ce_o, wr_addr_x0_o, wr_addr_x1_o,
             wr_en_o, stage_o, state_o
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 FFT stage sequencer: walks log2(N) stages of N/2
// butterflies, generates operand/twiddle addresses, and delays each address
// pair through a D-deep pipeline to produce the write-back addresses.
module fft_stage_sequencer #(
   parameter int N          = 1024,
   parameter int BF_LATENCY = 4,
   parameter int RD_LATENCY = 1
) (
   input logic clk,
   input logic rst,
   fft_stage_sequencer_if.master bus
);
   localparam int LOGN  = $clog2(N);
   localparam int TW_W  = LOGN - 1;
   localparam int STG_W = $clog2(LOGN);
   localparam int HALF  = N / 2;
   localparam int D     = RD_LATENCY + BF_LATENCY;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_reg, state_next;
   logic [STG_W-1:0] stage_reg, stage_next;
   logic [TW_W-1:0]  b_reg, b_next;

   logic             rd_en;
   logic             last_b, last_stage, pipe_empty;
   logic [LOGN-1:0]  b_ext, span, pos, grp, x0, x1, tw_full;
   logic [STG_W-1:0] tw_shift;
   logic [LOGN-1:0]  rd_x0, rd_x1;
   logic [TW_W-1:0]  rd_tw;

   logic [D:1]       valid_reg;
   logic [LOGN-1:0]  px0_reg [1:D];
   logic [LOGN-1:0]  px1_reg [1:D];

   assign rd_en      = (state_reg == S_READ);
   assign last_b     = (b_reg == TW_W'(HALF - 1));
   assign last_stage = (stage_reg == STG_W'(LOGN - 1));

   // Pipeline is drained once only the final slot may still hold a write;
   // that write lands on this edge, so the next stage may read next cycle.
   always_comb begin
      pipe_empty = 1'b1;
      for (int i = 1; i < D; i++) begin
         if (valid_reg[i]) pipe_empty = 1'b0;
      end
   end

   // Stage/butterfly control: next state, stage and butterfly index.
   always_comb begin
      state_next = state_reg;
      stage_next = stage_reg;
      b_next     = b_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.start_i) begin
               state_next = S_READ;
               stage_next = '0;
               b_next     = '0;
            end
         end
         S_READ: begin
            b_next = b_reg + TW_W'(1);   // wraps to 0 after N/2-1
            if (last_b) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (pipe_empty) begin
               if (last_stage) begin
                  state_next = S_DONE;
                  stage_next = '0;
               end else begin
                  state_next = S_READ;
                  stage_next = stage_reg + STG_W'(1);
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // FSM registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         stage_reg <= '0;
         b_reg     <= '0;
      end else begin
         state_reg <= state_next;
         stage_reg <= stage_next;
         b_reg     <= b_next;
      end
   end

   // Butterfly operand and twiddle addresses for the current stage.
   always_comb begin
      b_ext    = {1'b0, b_reg};
      span     = LOGN'(1) << stage_reg;
      pos      = b_ext & (span - LOGN'(1));
      grp      = b_ext >> stage_reg;
      x0       = ((grp << stage_reg) << 1) | pos;
      x1       = x0 + span;
      tw_shift = STG_W'(TW_W) - stage_reg;
      tw_full  = pos << tw_shift;
   end

   assign rd_x0 = rd_en ? x0 : '0;
   assign rd_x1 = rd_en ? x1 : '0;
   assign rd_tw = rd_en ? tw_full[TW_W-1:0] : '0;

   // First pipeline slot captures the pair issued this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg[1] <= 1'b0;
         px0_reg[1]   <= '0;
         px1_reg[1]   <= '0;
      end else begin
         valid_reg[1] <= rd_en;
         px0_reg[1]   <= rd_x0;
         px1_reg[1]   <= rd_x1;
      end
   end

   generate
      for (genvar gi = 2; gi <= D; gi++) begin : g_pipe
         // Shift slot gi-1 into slot gi.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
               px0_reg[gi]   <= '0;
               px1_reg[gi]   <= '0;
            end else begin
               valid_reg[gi] <= valid_reg[gi-1];
               px0_reg[gi]   <= px0_reg[gi-1];
               px1_reg[gi]   <= px1_reg[gi-1];
            end
         end
      end
   endgenerate

   assign bus.busy_o         = (state_reg != S_IDLE);
   assign bus.done_o         = (state_reg == S_DONE);
   assign bus.rd_en_o        = rd_en;
   assign bus.rd_addr_x0_o   = rd_x0;
   assign bus.rd_addr_x1_o   = rd_x1;
   assign bus.twiddle_addr_o = rd_tw;
   assign bus.bf_ce_o        = rd_en | (|valid_reg);
   assign bus.wr_en_o        = valid_reg[D];
   assign bus.wr_addr_x0_o   = valid_reg[D] ? px0_reg[D] : '0;
   assign bus.wr_addr_x1_o   = valid_reg[D] ? px1_reg[D] : '0;
   assign bus.stage_o        = stage_reg;
   assign bus.state_o        = state_reg;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for the FFT stage sequencer at N=8, D=5: full runs, a
// stray start during stage 1, reset during stage 1 drain, and reset vs start.
module tb_fft_stage_sequencer;
   localparam int N         = 8;
   localparam int D         = 5;
   localparam int STAGE_CYC = 9;    // N/2 + D
   localparam int RUN       = 27;   // 3 stages

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft_stage_sequencer_if #(.N(N)) bus();

   fft_stage_sequencer #(.N(N), .BF_LATENCY(4), .RD_LATENCY(1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // Hand-computed butterfly reads for stages 0,1,2.
   int rx0 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int rx1 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int rtw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Cycle k (1 = first cycle after the start edge) carries a read?
   function automatic bit is_read(input int k);
      return (k >= 1) && (k <= RUN) && (((k - 1) % STAGE_CYC) < 4);
   endfunction

   function automatic int rd_idx(input int k);
      return ((k - 1) / STAGE_CYC) * 4 + (k - 1) % STAGE_CYC;
   endfunction

   task automatic check_cycle(input string tag, input int k, input bit zero);
      int e_state = 0, e_stage = 0, e_busy = 0, e_done = 0;
      int e_rd = 0, e_x0 = 0, e_x1 = 0, e_tw = 0, e_ce = 0;
      int e_wr = 0, e_w0 = 0, e_w1 = 0;
      if (!zero && k >= 1) begin
         if (k <= RUN) begin
            e_state = is_read(k) ? 1 : 2;
            e_stage = (k - 1) / STAGE_CYC;
            e_busy  = 1;
         end else if (k == RUN + 1) begin
            e_state = 3;
            e_done  = 1;
            e_busy  = 1;
         end
         if (is_read(k)) begin
            e_rd = 1;
            e_x0 = rx0[rd_idx(k)];
            e_x1 = rx1[rd_idx(k)];
            e_tw = rtw[rd_idx(k)];
         end
         if (is_read(k - D)) begin
            e_wr = 1;
            e_w0 = rx0[rd_idx(k - D)];
            e_w1 = rx1[rd_idx(k - D)];
         end
         e_ce = e_rd;
         for (int d = 1; d <= D; d++) if (is_read(k - d)) e_ce = 1;
      end
      if (bus.rd_en_o || bus.wr_en_o)
         $display("%s k=%0d stage=%0d rd=%0d(%0d,%0d) tw=%0d wr=%0d(%0d,%0d)", tag, k,
                  bus.stage_o, bus.rd_en_o, bus.rd_addr_x0_o, bus.rd_addr_x1_o,
                  bus.twiddle_addr_o, bus.wr_en_o, bus.wr_addr_x0_o, bus.wr_addr_x1_o);
      check_eq($sformatf("%s k=%0d state", tag, k), 32'(bus.state_o), e_state);
      check_eq($sformatf("%s k=%0d stage", tag, k), 32'(bus.stage_o), e_stage);
      check_eq($sformatf("%s k=%0d busy", tag, k), 32'(bus.busy_o), e_busy);
      check_eq($sformatf("%s k=%0d done", tag, k), 32'(bus.done_o), e_done);
      check_eq($sformatf("%s k=%0d rd_en", tag, k), 32'(bus.rd_en_o), e_rd);
      check_eq($sformatf("%s k=%0d rd_x0", tag, k), 32'(bus.rd_addr_x0_o), e_x0);
      check_eq($sformatf("%s k=%0d rd_x1", tag, k), 32'(bus.rd_addr_x1_o), e_x1);
      check_eq($sformatf("%s k=%0d twiddle", tag, k), 32'(bus.twiddle_addr_o), e_tw);
      check_eq($sformatf("%s k=%0d bf_ce", tag, k), 32'(bus.bf_ce_o), e_ce);
      check_eq($sformatf("%s k=%0d wr_en", tag, k), 32'(bus.wr_en_o), e_wr);
      check_eq($sformatf("%s k=%0d wr_x0", tag, k), 32'(bus.wr_addr_x0_o), e_w0);
      check_eq($sformatf("%s k=%0d wr_x1", tag, k), 32'(bus.wr_addr_x1_o), e_w1);
   endtask

   // Pulse start, then check every cycle. Optionally re-pulse start at cycle
   // repulse_k, or assert reset at cycle rst_k (outputs must be 0 afterwards).
   task automatic run_fft(input string tag, input int repulse_k, input int rst_k);
      int last;
      last = (rst_k > 0) ? rst_k + 8 : RUN + 2;
      bus.start_i = 1'b1;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         bus.start_i = (k == repulse_k);
         rst         = (rst_k > 0) && (k == rst_k);
         check_cycle(tag, k, (rst_k > 0) && (k > rst_k));
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.start_i = 1'b0;
      repeat (3) @(negedge clk);
      check_cycle("reset", 0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check_cycle("idle", 0, 1'b1);

      run_fft("run1", 0, 0);
      run_fft("repulse", 12, 0);
      run_fft("rst_drain", 0, 15);
      run_fft("after_rst", 0, 0);

      // Reset wins over start in the same cycle.
      rst         = 1'b1;
      bus.start_i = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      bus.start_i = 1'b0;
      check_cycle("rst_vs_start", 0, 1'b1);
      @(negedge clk);
      check_cycle("rst_vs_start_next", 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
